// File: rtl/pll_rst_seq.sv
// PLL bring-up and staged reset-release sequencer.
// Holds the PLL in reset, waits for a qualified lock, then releases the
// downstream reset domains one at a time. Lock failures re-arm the PLL with a
// bounded retry budget, after which a sticky fault is raised.
module pll_rst_seq #(
  parameter int unsigned RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned STABLE_CYC   = 256,
  parameter int unsigned STAGES       = 3,
  parameter int unsigned STAGE_GAP    = 8,
  parameter int unsigned MAX_RETRY    = 3,
  localparam int unsigned RETRY_W     = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pll_locked_i,
  input  logic               restart_i,
  output logic               pll_rst_o,
  output logic [STAGES-1:0]  stage_rst_n_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  // One shared cycle counter serves every timed state; size it for the longest.
  localparam int unsigned MAX_AB = (RST_CYC > LOCK_TIMEOUT) ? RST_CYC : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (STABLE_CYC > STAGE_GAP) ? STABLE_CYC : STAGE_GAP;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    IDLE, PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               locked_meta;
  logic               locked_s;
  logic               fail_c;
  logic               restart_ok_c;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked_i;
      locked_s    <= locked_meta;
    end
  end

  // Failure detection (timeout or lock loss) and restart qualification.
  always_comb begin
    fail_c       = 1'b0;
    restart_ok_c = restart_i && (state != IDLE) && (state != FAULT);
    unique case (state)
      WAIT_LOCK:            fail_c = !locked_s && (cnt == CNT_W'(LOCK_TIMEOUT - 1));
      STABLE, RELEASE, RUN: fail_c = !locked_s;
      default:              fail_c = 1'b0;
    endcase
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      cnt           <= '0;
      pll_rst_o     <= 1'b1;
      stage_rst_n_o <= '0;
      ready_o       <= 1'b0;
      fault_o       <= 1'b0;
      retry_cnt_o   <= '0;
    end else if (restart_ok_c) begin
      state         <= PLL_RST;
      cnt           <= '0;
      pll_rst_o     <= 1'b1;
      stage_rst_n_o <= '0;
      ready_o       <= 1'b0;
    end else if (fail_c) begin
      cnt           <= '0;
      pll_rst_o     <= 1'b1;
      stage_rst_n_o <= '0;
      ready_o       <= 1'b0;
      if (retry_cnt_o == RETRY_W'(MAX_RETRY)) begin
        state   <= FAULT;
        fault_o <= 1'b1;
      end else begin
        state       <= PLL_RST;
        retry_cnt_o <= retry_cnt_o + RETRY_W'(1);
      end
    end else begin
      unique case (state)
        IDLE: begin
          state     <= PLL_RST;
          cnt       <= '0;
          pll_rst_o <= 1'b1;
        end
        PLL_RST: begin
          if (cnt == CNT_W'(RST_CYC - 1)) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_rst_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          if (cnt == CNT_W'(STABLE_CYC - 1)) begin
            state         <= RELEASE;
            cnt           <= '0;
            stage_rst_n_o <= STAGES'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (&stage_rst_n_o) begin
            state   <= RUN;
            ready_o <= 1'b1;
          end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
            cnt           <= '0;
            stage_rst_n_o <= (stage_rst_n_o << 1) | STAGES'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          ready_o <= 1'b1;
        end
        FAULT: begin
          pll_rst_o <= 1'b1;
          fault_o   <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
